// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative array divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_e;

    // Iteration counter width, never narrower than one bit.
    function automatic int counter_width(input int iterations);
        return (iterations > 1) ? $clog2(iterations) : 1;
    endfunction

endpackage

// File: rtl/restoring_divider_row.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not borrow.
module restoring_divider_row #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  dividend_bit_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  quotient_bit_o
);

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;
    logic                  borrow_lo;
    logic                  borrow;

    assign shifted = {rem_i, dividend_bit_i};

    // The shifted value's MSB can cover the borrow out of the low-word subtract.
    assign {borrow_lo, diff} = {1'b0, shifted[DATA_WIDTH-1:0]} - {1'b0, divisor_i};
    assign borrow            = borrow_lo & ~shifted[DATA_WIDTH];

    assign quotient_bit_o = ~borrow;
    assign rem_o          = borrow ? shifted[DATA_WIDTH-1:0] : diff;

endmodule

// File: rtl/iterative_array_divider.sv
// Unsigned iterative divider: BITS_PER_CYCLE chained restoring rows resolve that
// many quotient bits per cycle; a zero divisor short-circuits straight to DONE.
module iterative_array_divider
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  valid_o,
    output logic                  divide_by_zero_o
);

    localparam int               ITERATIONS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int               CNT_W      = counter_width(ITERATIONS);
    localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(ITERATIONS - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          count_q;
    logic [DATA_WIDTH-1:0]     work_q;
    logic [DATA_WIDTH-1:0]     divisor_q;
    logic [DATA_WIDTH-1:0]     rem_q;
    logic [DATA_WIDTH-1:0]     quotient_q;
    logic [DATA_WIDTH-1:0]     remainder_q;
    logic                      dbz_q;

    logic                      accept;
    logic                      divisor_zero;
    logic                      last_iter;
    logic [DATA_WIDTH-1:0]     rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_group;
    logic [DATA_WIDTH-1:0]     work_next;

    assign accept       = valid_i && (state_q == IDLE);
    assign divisor_zero = (divisor_i == '0);
    assign last_iter    = (count_q == LAST_ITER);

    // work_q shifts dividend bits out at the top while quotient bits enter at
    // the bottom, so after the last iteration it holds the full quotient.
    assign rem_chain[0] = rem_q;
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_row
        restoring_divider_row #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_row (
            .rem_i         (rem_chain[k]),
            .dividend_bit_i(work_q[DATA_WIDTH-1-k]),
            .divisor_i     (divisor_q),
            .rem_o         (rem_chain[k+1]),
            .quotient_bit_o(q_group[BITS_PER_CYCLE-1-k])
        );
    end
    assign work_next = (work_q << BITS_PER_CYCLE) | DATA_WIDTH'(q_group);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = divisor_zero ? DONE : DIVIDE;
            DIVIDE:  if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || accept)      count_q <= '0;
        else if (state_q == DIVIDE) count_q <= count_q + CNT_W'(1);
    end

    // NOTE: operand and working registers are not reset; they are always loaded on accept before use.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            work_q    <= dividend_i;
            divisor_q <= divisor_i;
            rem_q     <= '0;
        end else if (state_q == DIVIDE) begin
            work_q    <= work_next;
            rem_q     <= rem_chain[BITS_PER_CYCLE];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept && divisor_zero) begin
            quotient_q  <= '1;
            remainder_q <= dividend_i;
            dbz_q       <= 1'b1;
        end else if ((state_q == DIVIDE) && last_iter) begin
            quotient_q  <= work_next;
            remainder_q <= rem_chain[BITS_PER_CYCLE];
            dbz_q       <= 1'b0;
        end
    end

    assign ready_o          = (state_q == IDLE);
    assign valid_o          = (state_q == DONE);
    assign quotient_o       = quotient_q;
    assign remainder_o      = remainder_q;
    assign divide_by_zero_o = dbz_q;

endmodule
